// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// State encoding, BCD digit limits and the six-digit time bundle.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        CLEARED = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    localparam logic [3:0] CS_MAX    = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] DEC_MAX   = 4'd9;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD counter digit that rolls over after LIMIT.
// Ports: clk, reset, clr, inc in; value[3:0], carry out.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] LIMIT = DEC_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] value,
    output logic       carry
);

    assign carry = inc && (value == LIMIT);

    // >= so a corrupted out-of-range value recovers on the next increment
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= 4'd0;
        end else if (inc) begin
            value <= (value >= LIMIT) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear FSM with a BCD MM:SS.cc counter.
// Ports: clk, reset, tick, start_stop, lap_reset in; six BCD digits, running, lap_active out.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] cs_t,
    output logic [3:0] cs_u,
    output logic       running,
    output logic       lap_active
);

    localparam logic [3:0] MAX_T = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MINUTES % 10);

    state_t    state;
    state_t    state_nx;
    logic      count_en;
    logic      lap_load;
    logic      live_clr;
    logic      wrap;
    bcd_time_t live;
    bcd_time_t lap_q;
    bcd_time_t view;
    bcd_time_t disp_q;

    logic c_csu;
    logic c_cst;
    logic c_secu;
    logic c_sect;
    logic c_minu;
    logic carry_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEARED;
        end else begin
            state <= state_nx;
        end
    end

    // start_stop is tested first everywhere, so it wins over lap_reset
    always_comb begin
        state_nx = state;
        case (state)
            CLEARED: begin
                if (start_stop) state_nx = RUNNING;
            end
            RUNNING: begin
                if (start_stop)     state_nx = PAUSED;
                else if (lap_reset) state_nx = LAP;
            end
            LAP: begin
                if (start_stop)     state_nx = PAUSED;
                else if (lap_reset) state_nx = RUNNING;
            end
            PAUSED: begin
                if (start_stop)     state_nx = RUNNING;
                else if (lap_reset) state_nx = CLEARED;
            end
            default: state_nx = CLEARED;
        endcase
    end

    always_comb begin
        running    = 1'b0;
        lap_active = 1'b0;
        count_en   = 1'b0;
        lap_load   = 1'b0;
        live_clr   = 1'b0;
        unique case (1'b1)
            state == RUNNING: begin
                running  = 1'b1;
                count_en = tick;
                lap_load = lap_reset && !start_stop;
            end
            state == LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
                count_en   = tick;
            end
            state == PAUSED: begin
                live_clr = lap_reset && !start_stop;
            end
            default: begin
            end
        endcase
    end

    // Terminal minute plus a seconds carry forces the minute pair to 00
    assign wrap = c_sect && (live.min_t == MAX_T) && (live.min_u == MAX_U);

    bcd_digit #(.LIMIT(CS_MAX)) u_cs_u (
        .clk(clk), .reset(reset), .clr(live_clr), .inc(count_en),
        .value(live.cs_u), .carry(c_csu)
    );

    bcd_digit #(.LIMIT(CS_MAX)) u_cs_t (
        .clk(clk), .reset(reset), .clr(live_clr), .inc(c_csu),
        .value(live.cs_t), .carry(c_cst)
    );

    bcd_digit #(.LIMIT(DEC_MAX)) u_sec_u (
        .clk(clk), .reset(reset), .clr(live_clr), .inc(c_cst),
        .value(live.sec_u), .carry(c_secu)
    );

    bcd_digit #(.LIMIT(SEC_T_MAX)) u_sec_t (
        .clk(clk), .reset(reset), .clr(live_clr), .inc(c_secu),
        .value(live.sec_t), .carry(c_sect)
    );

    bcd_digit #(.LIMIT(DEC_MAX)) u_min_u (
        .clk(clk), .reset(reset), .clr(live_clr || wrap), .inc(c_sect),
        .value(live.min_u), .carry(c_minu)
    );

    bcd_digit #(.LIMIT(DEC_MAX)) u_min_t (
        .clk(clk), .reset(reset), .clr(live_clr || wrap), .inc(c_minu),
        .value(live.min_t), .carry(carry_unused)
    );

    // Latch captures the live count as it stood before the lap edge
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q <= '0;
        end else if (lap_load) begin
            lap_q <= live;
        end
    end

    assign view = (state == LAP) ? lap_q : live;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q <= '0;
        end else begin
            disp_q <= view;
        end
    end

    assign min_t = disp_q.min_t;
    assign min_u = disp_q.min_u;
    assign sec_t = disp_q.sec_t;
    assign sec_u = disp_q.sec_u;
    assign cs_t  = disp_q.cs_t;
    assign cs_u  = disp_q.cs_u;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (MAX_MINUTES 59 and 1).
// Both instances share stimulus; a centisecond-count model predicts outputs.
module tb_stopwatch_ctrl;

    localparam int S_CLR = 0;
    localparam int S_RUN = 1;
    localparam int S_PAU = 2;
    localparam int S_LAP = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic start_stop = 1'b0;
    logic lap_reset = 1'b0;

    logic [3:0] a_mt, a_mu, a_st, a_su, a_ct, a_cu;
    logic [3:0] b_mt, b_mu, b_st, b_su, b_ct, b_cu;
    logic       a_run, a_lap, b_run, b_lap;

    logic [23:0] obs0;
    logic [23:0] obs1;
    logic [1:0]  flg0;
    logic [1:0]  flg1;

    int total = 0;
    int bad = 0;

    int m_st[2];
    int m_live[2];
    int m_lap[2];
    int m_disp[2];
    int m_max[2] = '{59, 1};

    always #5 clk = ~clk;

    stopwatch_ctrl dut0 (
        .clk(clk), .reset(reset), .tick(tick),
        .start_stop(start_stop), .lap_reset(lap_reset),
        .min_t(a_mt), .min_u(a_mu), .sec_t(a_st), .sec_u(a_su),
        .cs_t(a_ct), .cs_u(a_cu), .running(a_run), .lap_active(a_lap)
    );

    stopwatch_ctrl #(.MAX_MINUTES(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick),
        .start_stop(start_stop), .lap_reset(lap_reset),
        .min_t(b_mt), .min_u(b_mu), .sec_t(b_st), .sec_u(b_su),
        .cs_t(b_ct), .cs_u(b_cu), .running(b_run), .lap_active(b_lap)
    );

    assign obs0 = {a_mt, a_mu, a_st, a_su, a_ct, a_cu};
    assign obs1 = {b_mt, b_mu, b_st, b_su, b_ct, b_cu};
    assign flg0 = {a_run, a_lap};
    assign flg1 = {b_run, b_lap};

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [1:0] exp_flg(input int k);
        return {m_st[k] == S_RUN || m_st[k] == S_LAP, m_st[k] == S_LAP};
    endfunction

    task automatic cyc(input logic ss, input logic lr, input logic tk,
                       input logic rst);
        int nlive;
        logic cnt;
        start_stop = ss;
        lap_reset  = lr;
        tick       = tk;
        reset      = rst;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = S_CLR;
                m_live[k] = 0;
                m_lap[k] = 0;
                m_disp[k] = 0;
            end else begin
                m_disp[k] = (m_st[k] == S_LAP) ? m_lap[k] : m_live[k];
                cnt = tk && (m_st[k] == S_RUN || m_st[k] == S_LAP);
                nlive = cnt ? (m_live[k] + 1) % ((m_max[k] + 1) * 6000)
                            : m_live[k];
                case (m_st[k])
                    S_CLR: if (ss) m_st[k] = S_RUN;
                    S_RUN: begin
                        if (ss) m_st[k] = S_PAU;
                        else if (lr) begin
                            m_st[k] = S_LAP;
                            m_lap[k] = m_live[k];
                        end
                    end
                    S_LAP: begin
                        if (ss) m_st[k] = S_PAU;
                        else if (lr) m_st[k] = S_RUN;
                    end
                    default: begin
                        if (ss) m_st[k] = S_RUN;
                        else if (lr) begin
                            m_st[k] = S_CLR;
                            nlive = 0;
                        end
                    end
                endcase
                m_live[k] = nlive;
            end
        end
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        tick       = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs0 !== 24'h0 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL reset0 got=%h/%b want=000000/00", obs0, flg0);
        end
        total++;
        if (obs1 !== 24'h0 || flg1 !== 2'b00) begin
            bad++;
            $display("FAIL reset1 got=%h/%b want=000000/00", obs1, flg1);
        end
    endtask

    task automatic test_run();
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(1234);
        idle();
        total++;
        if (obs0 !== 24'h001234 || obs0 !== to_bcd(m_disp[0])) begin
            bad++;
            $display("FAIL run_disp got=%h want=001234", obs0);
        end
        total++;
        if (flg0 !== 2'b10) begin
            bad++;
            $display("FAIL run_flags got=%b want=10", flg0);
        end
    endtask

    task automatic test_lap();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(500);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(300);
        total++;
        if (obs0 !== 24'h000500 || flg0 !== 2'b11) begin
            bad++;
            $display("FAIL lap_frozen got=%h/%b want=000500/11", obs0, flg0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs0 !== 24'h000500 || flg0 !== 2'b10) begin
            bad++;
            $display("FAIL lap_exit got=%h/%b want=000500/10", obs0, flg0);
        end
        idle();
        total++;
        if (obs0 !== 24'h000800 || obs0 !== to_bcd(m_disp[0])) begin
            bad++;
            $display("FAIL lap_live got=%h want=000800", obs0);
        end
    endtask

    task automatic test_pause_clear();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(250);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        idle();
        total++;
        if (obs0 !== 24'h000250 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL pause_hold got=%h/%b want=000250/00", obs0, flg0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        total++;
        if (obs0 !== 24'h0 || m_st[0] != S_CLR) begin
            bad++;
            $display("FAIL pause_clear got=%h want=000000", obs0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        total++;
        if (obs0 !== 24'h0 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL clr_ignore got=%h/%b want=000000/00", obs0, flg0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(50);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        total++;
        if (obs0 !== 24'h000151 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL both_pause got=%h/%b want=000151/00", obs0, flg0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        total++;
        if (obs0 !== 24'h000151 || flg0 !== 2'b10) begin
            bad++;
            $display("FAIL resume_tick got=%h/%b want=000151/10", obs0, flg0);
        end
    endtask

    task automatic test_reset_in_lap();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (obs0 !== 24'h0 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL lap_reset got=%h/%b want=000000/00", obs0, flg0);
        end
        ticks(1);
        idle();
        total++;
        if (obs0 !== 24'h0 || flg0 !== 2'b00) begin
            bad++;
            $display("FAIL post_reset got=%h/%b want=000000/00", obs0, flg0);
        end
    endtask

    task automatic test_random();
        logic ss, lr, tk, rs;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            ss = ($urandom_range(0, 19) == 0);
            lr = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 499) == 0);
            cyc(ss, lr, tk, rs);
            total++;
            if (obs0 !== to_bcd(m_disp[0]) || flg0 !== exp_flg(0)) begin
                bad++;
                $display("FAIL rand0 cyc=%0d got=%h/%b want=%h/%b", i,
                         obs0, flg0, to_bcd(m_disp[0]), exp_flg(0));
            end
            total++;
            if (obs1 !== to_bcd(m_disp[1]) || flg1 !== exp_flg(1)) begin
                bad++;
                $display("FAIL rand1 cyc=%0d got=%h/%b want=%h/%b", i,
                         obs1, flg1, to_bcd(m_disp[1]), exp_flg(1));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(11999);
        idle();
        total++;
        if (obs1 !== 24'h015999 || obs0 !== 24'h015999) begin
            bad++;
            $display("FAIL pre_wrap got=%h/%h want=015999", obs1, obs0);
        end
        ticks(1);
        idle();
        total++;
        if (obs1 !== 24'h0 || flg1 !== 2'b10) begin
            bad++;
            $display("FAIL wrap1 got=%h/%b want=000000/10", obs1, flg1);
        end
        total++;
        if (obs0 !== 24'h020000) begin
            bad++;
            $display("FAIL no_wrap0 got=%h want=020000", obs0);
        end
        ticks(48500);
        idle();
        total++;
        if (obs0 !== 24'h100500 || obs0 !== to_bcd(m_disp[0])) begin
            bad++;
            $display("FAIL ten_min got=%h want=100500", obs0);
        end
        total++;
        if (obs1 !== to_bcd(m_disp[1])) begin
            bad++;
            $display("FAIL long1 got=%h want=%h", obs1, to_bcd(m_disp[1]));
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_lap();
        test_pause_clear();
        test_simultaneous();
        test_reset_in_lap();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
